decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 222 ++++++++++++++++++++++
 tb/tb_decode_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//   Single-entry instruction decode stage with a per-register write
//   scoreboard. An instruction is accepted when the output slot is free (or
//   draining this cycle) and none of its operands is waiting on a write. The
//   decoded bundle appears one cycle after acceptance and is held until the
//   consumer takes it.
//
// Optional feature:
//   DECODE_TRAP_EN - when defined, reserved encodings (class 11 op 0111/1110,
//                    class 10 sub-op 110) are flagged on out_illegal. They
//                    perform no register write and reserve no scoreboard
//                    entry. When undefined, out_illegal is constant 0.
//
// Ports:
//   clk, rst     - clock; synchronous active-high reset
//   in_valid     - instruction offered on in_instr
//   in_instr     - instruction word (decode fields live in bits [15:0])
//   in_ready     - stage accepts in_instr this cycle
//   out_valid    - decoded bundle valid
//   out_ready    - consumer accepts the bundle
//   flush        - drop the held bundle and refuse the current input
//   wb_valid     - a register write retires this cycle
//   wb_addr      - register being retired
//   out_instr    - registered copy of the accepted instruction
//   out_alu_sel  - ALU select
//   out_reg_we   - register write enable
//   out_wr_addr  - register written
//   out_mem_we   - memory write (stores)
//   out_pc_load  - branch taken-path load
//   out_cond     - condition field, bits [10:8]
//   out_illegal  - reserved encoding seen
// ---------------------------------------------------------------------------
module decode_stage #(
  parameter int INSTR_W  = 16,
  parameter int REG_AW   = 3,
  parameter int SB_DEPTH = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  input  logic               flush,
  input  logic               wb_valid,
  input  logic [REG_AW-1:0]  wb_addr,
  output logic [INSTR_W-1:0] out_instr,
  output logic [3:0]         out_alu_sel,
  output logic               out_reg_we,
  output logic [REG_AW-1:0]  out_wr_addr,
  output logic               out_mem_we,
  output logic               out_pc_load,
  output logic [2:0]         out_cond,
  output logic               out_illegal
);

  localparam int NREG  = 2 ** REG_AW;
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  logic [1:0]        cls;
  logic [2:0]        sub_op;
  logic [3:0]        op;
  logic [REG_AW-1:0] src_a;
  logic [REG_AW-1:0] src_b;

  assign cls    = in_instr[15:14];
  assign sub_op = in_instr[13:11];
  assign op     = in_instr[7:4];
  assign src_a  = REG_AW'(in_instr[13:11]);
  assign src_b  = REG_AW'(in_instr[10:8]);

  logic [3:0]        dec_alu_sel;
  logic              dec_reg_we;
  logic [REG_AW-1:0] dec_wr_addr;
  logic              dec_mem_we;
  logic              dec_pc_load;
  logic              dec_illegal;
  logic              uses_a;
  logic              uses_b;

  // Field decode of the offered instruction. Source usage is decoded here
  // too so the hazard check only looks at registers the instruction reads.
  always_comb begin
    dec_alu_sel = 4'b0000;
    dec_reg_we  = 1'b0;
    dec_wr_addr = '0;
    dec_mem_we  = 1'b0;
    dec_pc_load = 1'b0;
    dec_illegal = 1'b0;
    uses_a      = 1'b0;
    uses_b      = 1'b0;
    case (cls)
      2'b00: begin
        uses_b      = 1'b1;
        dec_reg_we  = 1'b1;
        dec_wr_addr = src_a;
      end
      2'b01: begin
        uses_a     = 1'b1;
        uses_b     = 1'b1;
        dec_mem_we = 1'b1;
      end
      2'b10: begin
        uses_b      = (sub_op == 3'b001);
        dec_pc_load = (sub_op == 3'b100) || (sub_op == 3'b111);
        if ((sub_op == 3'b000) || (sub_op == 3'b001)) begin
          dec_reg_we  = 1'b1;
          dec_wr_addr = src_b;
        end
        case (sub_op)
          3'b000:                 dec_alu_sel = 4'b1100;
          3'b001, 3'b100, 3'b111: dec_alu_sel = 4'b0000;
          default:                dec_alu_sel = 4'b1111;
        endcase
      end
      default: begin
        uses_a = 1'b1;
        uses_b = 1'b1;
        if ((op <= 4'b1100) && (op != 4'b0101)) begin
          dec_reg_we  = 1'b1;
          dec_wr_addr = src_b;
        end
        case (op)
          4'b0101: dec_alu_sel = 4'b0001;
          4'b0110: dec_alu_sel = 4'b1100;
          default: dec_alu_sel = op;
        endcase
      end
    endcase
`ifdef DECODE_TRAP_EN
    dec_illegal = ((cls == 2'b11) && ((op == 4'b0111) || (op == 4'b1110))) ||
                  ((cls == 2'b10) && (sub_op == 3'b110));
    if (dec_illegal) begin
      dec_reg_we  = 1'b0;
      dec_wr_addr = '0;
      dec_mem_we  = 1'b0;
      dec_pc_load = 1'b0;
      dec_alu_sel = 4'b1111;
    end
`else
    dec_illegal = 1'b0;
`endif
  end

  logic [CNT_W-1:0] sb_cnt [NREG];
  logic             hazard;
  logic             fire;

  // The destination only stalls once its counter is full, so a register can
  // carry up to SB_DEPTH writes in flight; readers wait for the count to
  // drain to zero. Counts are taken from the registered state, so a
  // retirement in the same cycle does not release a stall early.
  always_comb begin
    hazard = (uses_a && (sb_cnt[src_a] != '0)) ||
             (uses_b && (sb_cnt[src_b] != '0)) ||
             (dec_reg_we && (sb_cnt[dec_wr_addr] == CNT_W'(SB_DEPTH)));
  end

  assign in_ready = !rst && !hazard && !flush && (!out_valid || out_ready);
  assign fire     = in_valid && in_ready;

  logic [NREG-1:0] sb_inc;
  logic [NREG-1:0] sb_dec;

  // Per-register increment/decrement requests. A retirement against an
  // empty counter is dropped so the counter never wraps below zero.
  always_comb begin
    sb_inc = '0;
    sb_dec = '0;
    for (int i = 0; i < NREG; i++) begin
      sb_inc[i] = fire && dec_reg_we && (dec_wr_addr == REG_AW'(i));
      sb_dec[i] = wb_valid && (wb_addr == REG_AW'(i)) && (sb_cnt[i] != '0);
    end
  end

  // Scoreboard counters; a simultaneous issue and retirement on the same
  // register cancel out.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) sb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        case ({sb_inc[i], sb_dec[i]})
          2'b10:   sb_cnt[i] <= sb_cnt[i] + CNT_W'(1);
          2'b01:   sb_cnt[i] <= sb_cnt[i] - CNT_W'(1);
          default: sb_cnt[i] <= sb_cnt[i];
        endcase
      end
    end
  end

  // Output bundle register. Loading only on fire keeps the bundle stable
  // while the consumer stalls; flush or a completed handshake empties it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_instr   <= '0;
      out_alu_sel <= 4'b0000;
      out_reg_we  <= 1'b0;
      out_wr_addr <= '0;
      out_mem_we  <= 1'b0;
      out_pc_load <= 1'b0;
      out_cond    <= 3'b000;
      out_illegal <= 1'b0;
    end else if (fire) begin
      out_valid   <= 1'b1;
      out_instr   <= in_instr;
      out_alu_sel <= dec_alu_sel;
      out_reg_we  <= dec_reg_we;
      out_wr_addr <= dec_wr_addr;
      out_mem_we  <= dec_mem_we;
      out_pc_load <= dec_pc_load;
      out_cond    <= in_instr[10:8];
      out_illegal <= dec_illegal;
    end else if (flush || out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//   Directed bench for decode_stage: a table of single-instruction decodes
//   followed by hand-written multi-cycle sequences for hazards, backpressure,
//   flush, scoreboard saturation and mid-handshake reset. Inputs change on
//   the falling edge; outputs are sampled on the falling edge (or 1 time
//   unit after an input change for the combinational in_ready).
// ---------------------------------------------------------------------------
module tb_decode_stage;

  localparam int INSTR_W  = 16;
  localparam int REG_AW   = 3;
  localparam int SB_DEPTH = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic [INSTR_W-1:0] in_instr;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic               flush;
  logic               wb_valid;
  logic [REG_AW-1:0]  wb_addr;
  logic [INSTR_W-1:0] out_instr;
  logic [3:0]         out_alu_sel;
  logic               out_reg_we;
  logic [REG_AW-1:0]  out_wr_addr;
  logic               out_mem_we;
  logic               out_pc_load;
  logic [2:0]         out_cond;
  logic               out_illegal;

  decode_stage #(
    .INSTR_W  (INSTR_W),
    .REG_AW   (REG_AW),
    .SB_DEPTH (SB_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_instr    (in_instr),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .flush       (flush),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .out_instr   (out_instr),
    .out_alu_sel (out_alu_sel),
    .out_reg_we  (out_reg_we),
    .out_wr_addr (out_wr_addr),
    .out_mem_we  (out_mem_we),
    .out_pc_load (out_pc_load),
    .out_cond    (out_cond),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  alu;
    logic        we;
    logic [2:0]  wr;
    logic        mem;
    logic        pc;
    logic [2:0]  cond;
    logic        ill;
  } vec_t;

  vec_t vecs[$];
  vec_t v;
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t mk(input logic [15:0] instr, input logic [3:0] alu,
                              input logic we, input logic [2:0] wr,
                              input logic mem, input logic pc,
                              input logic [2:0] cond, input logic ill);
    vec_t r;
    r.instr = instr; r.alu = alu; r.we = we; r.wr = wr;
    r.mem = mem; r.pc = pc; r.cond = cond; r.ill = ill;
    return r;
  endfunction

  // Drives every DUT input except reset in one call.
  task automatic applyStimulus(input logic iv, input logic [15:0] instr,
                               input logic ordy, input logic fl,
                               input logic wv, input logic [2:0] wa);
    in_valid  = iv;
    in_instr  = instr;
    out_ready = ordy;
    flush     = fl;
    wb_valid  = wv;
    wb_addr   = wa;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Decode table: instr, alu_sel, reg_we, wr_addr, mem_we, pc_load, cond, illegal
    vecs.push_back(mk(16'hC150, 4'b0001, 1'b0, 3'd0, 1'b0, 1'b0, 3'd1, 1'b0)); // CMP
    vecs.push_back(mk(16'hCB30, 4'b0011, 1'b1, 3'd3, 1'b0, 1'b0, 3'd3, 1'b0)); // op 0011
    vecs.push_back(mk(16'hC460, 4'b1100, 1'b1, 3'd4, 1'b0, 1'b0, 3'd4, 1'b0)); // op 0110
    vecs.push_back(mk(16'hC7D0, 4'b1101, 1'b0, 3'd0, 1'b0, 1'b0, 3'd7, 1'b0)); // op 1101
    vecs.push_back(mk(16'hC1C0, 4'b1100, 1'b1, 3'd1, 1'b0, 1'b0, 3'd1, 1'b0)); // op 1100
    vecs.push_back(mk(16'h1800, 4'b0000, 1'b1, 3'd3, 1'b0, 1'b0, 3'd0, 1'b0)); // LD R3
    vecs.push_back(mk(16'h4A00, 4'b0000, 1'b0, 3'd0, 1'b1, 1'b0, 3'd2, 1'b0)); // ST
    vecs.push_back(mk(16'h8500, 4'b1100, 1'b1, 3'd5, 1'b0, 1'b0, 3'd5, 1'b0)); // sub 000
    vecs.push_back(mk(16'h8E00, 4'b0000, 1'b1, 3'd6, 1'b0, 1'b0, 3'd6, 1'b0)); // sub 001
    vecs.push_back(mk(16'hA300, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd3, 1'b0)); // sub 100
    vecs.push_back(mk(16'hB900, 4'b0000, 1'b0, 3'd0, 1'b0, 1'b1, 3'd1, 1'b0)); // sub 111
    vecs.push_back(mk(16'h9200, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0)); // sub 010
`ifdef DECODE_TRAP_EN
    vecs.push_back(mk(16'hB200, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1)); // sub 110
    vecs.push_back(mk(16'hC270, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b1)); // op 0111
    vecs.push_back(mk(16'hC3E0, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b1)); // op 1110
`else
    vecs.push_back(mk(16'hB200, 4'b1111, 1'b0, 3'd0, 1'b0, 1'b0, 3'd2, 1'b0)); // sub 110
    vecs.push_back(mk(16'hC270, 4'b0111, 1'b1, 3'd2, 1'b0, 1'b0, 3'd2, 1'b0)); // op 0111
    vecs.push_back(mk(16'hC3E0, 4'b1110, 1'b0, 3'd0, 1'b0, 1'b0, 3'd3, 1'b0)); // op 1110
`endif

    // Reset with an instruction offered: nothing accepted, outputs cleared.
    rst = 1'b1;
    applyStimulus(1'b1, 16'h1800, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_out_instr", {16'd0, out_instr}, 32'd0);
    checkOutput("rst_alu_sel", {28'd0, out_alu_sel}, 32'd0);
    checkOutput("rst_reg_we", {31'd0, out_reg_we}, 32'd0);
    checkOutput("rst_wr_addr", {29'd0, out_wr_addr}, 32'd0);
    checkOutput("rst_cond", {29'd0, out_cond}, 32'd0);
    checkOutput("rst_illegal", {31'd0, out_illegal}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);

    // Table-driven single decodes; each write is retired right after.
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      applyStimulus(1'b1, v.instr, 1'b1, 1'b0, 1'b0, 3'd0);
      #1;
      checkOutput($sformatf("v%0d_in_ready", i), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      checkOutput($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("v%0d_instr", i), {16'd0, out_instr}, {16'd0, v.instr});
      checkOutput($sformatf("v%0d_alu_sel", i), {28'd0, out_alu_sel}, {28'd0, v.alu});
      checkOutput($sformatf("v%0d_reg_we", i), {31'd0, out_reg_we}, {31'd0, v.we});
      checkOutput($sformatf("v%0d_wr_addr", i), {29'd0, out_wr_addr}, {29'd0, v.wr});
      checkOutput($sformatf("v%0d_mem_we", i), {31'd0, out_mem_we}, {31'd0, v.mem});
      checkOutput($sformatf("v%0d_pc_load", i), {31'd0, out_pc_load}, {31'd0, v.pc});
      checkOutput($sformatf("v%0d_cond", i), {29'd0, out_cond}, {29'd0, v.cond});
      checkOutput($sformatf("v%0d_illegal", i), {31'd0, out_illegal}, {31'd0, v.ill});
      applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, v.we, v.wr);
      @(negedge clk);
    end
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("drain_out_valid", {31'd0, out_valid}, 32'd0);

    // RAW hazard: ADD reading R3 waits for the LD to R3 to retire.
    applyStimulus(1'b1, 16'h1800, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("raw_ld_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b1, 16'hD820, 1'b1, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("raw_stall%0d", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    applyStimulus(1'b1, 16'hD820, 1'b1, 1'b0, 1'b1, 3'd3);
    #1;
    checkOutput("raw_stall_during_wb", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b1, 16'hD820, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("raw_release", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    checkOutput("raw_add_alu", {28'd0, out_alu_sel}, 32'd2);
    checkOutput("raw_add_wr", {29'd0, out_wr_addr}, 32'd0);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0);
    @(negedge clk);

    // Issue to R3 together with a retirement of R3 keeps its count at 1.
    applyStimulus(1'b1, 16'h1800, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    applyStimulus(1'b1, 16'h1800, 1'b1, 1'b0, 1'b1, 3'd3);
    #1;
    checkOutput("sim_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    applyStimulus(1'b0, 16'hD820, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("sim_count_nonzero", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 16'hD820, 1'b1, 1'b0, 1'b1, 3'd3);
    @(negedge clk);
    applyStimulus(1'b0, 16'hD820, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("sim_count_one", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Backpressure: ST held for three cycles, then CMP accepted on release.
    applyStimulus(1'b1, 16'h4A00, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("bp_first_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(1'b1, 16'hC150, 1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 3; k++) begin
      #1;
      checkOutput($sformatf("bp_ready%0d", k), {31'd0, in_ready}, 32'd0);
      @(negedge clk);
      checkOutput($sformatf("bp_hold_instr%0d", k), {16'd0, out_instr}, 32'h4A00);
      checkOutput($sformatf("bp_hold_valid%0d", k), {31'd0, out_valid}, 32'd1);
      checkOutput($sformatf("bp_hold_mem%0d", k), {31'd0, out_mem_we}, 32'd1);
    end
    applyStimulus(1'b1, 16'hC150, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    checkOutput("bp_next_instr", {16'd0, out_instr}, 32'hC150);
    checkOutput("bp_next_alu", {28'd0, out_alu_sel}, 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("bp_drain_valid", {31'd0, out_valid}, 32'd0);

    // Flush while holding LD R3 and offering a write to R5.
    applyStimulus(1'b1, 16'h1800, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("fl_held_valid", {31'd0, out_valid}, 32'd1);
    applyStimulus(1'b1, 16'h8500, 1'b0, 1'b1, 1'b0, 3'd0);
    #1;
    checkOutput("fl_blocks_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 16'hD820, 1'b1, 1'b0, 1'b0, 3'd0);
    checkOutput("fl_clears_valid", {31'd0, out_valid}, 32'd0);
    #1;
    checkOutput("fl_keeps_r3", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 16'hE8D0, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("fl_no_r5_inc", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd3);
    @(negedge clk);

    // Saturation: three writes to R5 fill its counter, the fourth stalls.
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 16'h8500, 1'b1, 1'b0, 1'b0, 3'd0);
      #1;
      checkOutput($sformatf("sat_w%0d", k), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
    end
    #1;
    checkOutput("sat_stall", {31'd0, in_ready}, 32'd0);
    applyStimulus(1'b0, 16'h8500, 1'b1, 1'b0, 1'b1, 3'd5);
    @(negedge clk);
    #1;
    checkOutput("sat_release", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 16'h8500, 1'b1, 1'b0, 1'b1, 3'd5);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);   // extra retirement on an empty counter
    applyStimulus(1'b0, 16'hE8D0, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("nowrap_read", {31'd0, in_ready}, 32'd1);
    applyStimulus(1'b0, 16'h8500, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("nowrap_write", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    // Reset while a bundle is held mid-handshake drops it and clears R3.
    applyStimulus(1'b1, 16'h1800, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    rst = 1'b1;
    applyStimulus(1'b1, 16'hC150, 1'b0, 1'b0, 1'b0, 3'd0);
    @(negedge clk);
    checkOutput("mrst_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("mrst_instr", {16'd0, out_instr}, 32'd0);
    checkOutput("mrst_reg_we", {31'd0, out_reg_we}, 32'd0);
    checkOutput("mrst_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    applyStimulus(1'b0, 16'hD820, 1'b1, 1'b0, 1'b0, 3'd0);
    #1;
    checkOutput("mrst_sb_cleared", {31'd0, in_ready}, 32'd1);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
